// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and defaults for the PLL lock supervisor
package pll_sup_pkg;

    localparam int LOCK_LOSS_CNT_W          = 8;

    localparam int DEF_RST_PULSE_CYCLES     = 16;
    localparam int DEF_LOCK_STABLE_CYCLES   = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES  = 65536;
    localparam int DEF_MAX_RETRIES          = 3;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// rtl/pll_sup_sync2.sv - two-flop synchroniser for one asynchronous status bit
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronised output, two clk edges behind d
module pll_sup_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset, qualifies lock, releases system reset
//   clk           : free-running reference clock (not a PLL output)
//   reset_n       : asynchronous active-low reset
//   pll_locked    : PLL lock indicator, asynchronous to clk
//   soft_reset    : single-cycle request to restart the sequence (top priority)
//   pll_rst       : active-high reset to the PLL
//   sys_reset_n   : active-low reset for downstream logic, released only in RUN
//   ready         : high only in RUN
//   fail          : high only in FAIL
//   lock_loss_cnt : saturating count of lock losses seen in RUN
// Optional macro PLL_SUP_AUTO_RETRY_EN: retry up to MAX_RETRIES times after a
// lock timeout before entering FAIL; without it the first timeout is fatal.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pll_locked,
    input  logic                       soft_reset,
    output logic                       pll_rst,
    output logic                       sys_reset_n,
    output logic                       ready,
    output logic                       fail,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    if (RST_PULSE_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
        LOCK_TIMEOUT_CYCLES < 2 || MAX_RETRIES < 0) begin : g_bad_params
        $error("pll_lock_supervisor: parameter out of range");
    end

    logic                       locked_s;
    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [LOCK_LOSS_CNT_W-1:0] llc_nxt;

    pll_sup_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

`ifdef PLL_SUP_AUTO_RETRY_EN
    localparam int RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [RETRY_W-1:0] retry, retry_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry <= '0;
        end else begin
            retry <= retry_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        llc_nxt   = lock_loss_cnt;
`ifdef PLL_SUP_AUTO_RETRY_EN
        retry_nxt = retry;
`endif
        if (soft_reset) begin
            state_nxt = PLL_RST;
`ifdef PLL_SUP_AUTO_RETRY_EN
            retry_nxt = '0;
`endif
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
`ifdef PLL_SUP_AUTO_RETRY_EN
                        if (retry < RETRY_MAX) begin
                            retry_nxt = retry + 1'b1;
                            state_nxt = PLL_RST;
                        end else begin
                            state_nxt = FAIL;
                        end
`else
                        state_nxt = FAIL;
`endif
                    end
                end
                STABLE: begin
                    // A dropout anywhere in the window, including its last
                    // cycle, sends us back to wait with a fresh timeout.
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    cnt_nxt = '0;
                    if (!locked_s) begin
                        if (lock_loss_cnt != '1) llc_nxt = lock_loss_cnt + 1'b1;
`ifdef PLL_SUP_AUTO_RETRY_EN
                        retry_nxt = '0;
`endif
                        state_nxt = PLL_RST;
                    end
                end
                FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = PLL_RST;
                end
            endcase
        end
        // soft_reset also restarts the pulse when already in PLL_RST.
        if (soft_reset || state_nxt != state) cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the state register and never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pll_rst       <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
            sys_reset_n   <= (state_nxt == RUN);
            ready         <= (state_nxt == RUN);
            fail          <= (state_nxt == FAIL);
            lock_loss_cnt <= llc_nxt;
        end
    end

endmodule
